// File: rtl/key_schedule_ctrl_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM encoding, Rcon and S-box.
package key_schedule_ctrl_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Forward S-box, byte 0x00 in the top 8 bits, 0xff in the bottom 8 bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/KeyExpansionRound.sv
// One AES-128 key-expansion step: previous round key in, next round key out.
module KeyExpansionRound
  import key_schedule_ctrl_pkg::*;
(
  input  logic [3:0]   roundCount,
  input  logic [127:0] keyIn,
  output logic [127:0] keyOut
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = keyIn[127:96];
  assign w1 = keyIn[95:64];
  assign w2 = keyIn[63:32];
  assign w3 = keyIn[31:0];

  assign t  = subWord({w3[23:0], w3[31:24]}) ^ {rcon(roundCount), 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign keyOut = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key schedule: one shared round step reused over 10 cycles,
// 11-entry round-key store, registered read port and flat store export.
//
// state  | meaning
// IDLE   | no schedule yet; waiting for start
// EXPAND | generating round key roundCnt this cycle
// READY  | all 11 round keys valid; start restarts
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int KEY_W      = AES_KEY_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [KEY_W-1:0]                keyIn,
  output logic                            busy,
  output logic                            ready,
  output logic                            done,
  input  logic [3:0]                      rdRound,
  output logic [KEY_W-1:0]                rdKey,
  output logic                            rdValid,
  output logic [(NUM_ROUNDS+1)*KEY_W-1:0] keysOut
);

  if (NUM_ROUNDS != 10 || KEY_W != 128) begin : gBadParam
    $error("key_schedule_ctrl supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t state, nextState;

  logic [3:0]            roundCnt;
  logic [NUM_ROUNDS:0]   validMask;
  logic [KEY_W-1:0]      store [0:NUM_ROUNDS];
  logic [3:0]            prevIdx;
  logic [KEY_W-1:0]      prevKey;
  logic [KEY_W-1:0]      nextKey;
  logic                  startAccept;
  logic                  expandStep;
  logic                  lastStep;
  logic                  doneReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState   = state;
    startAccept = 1'b0;
    expandStep  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          startAccept = 1'b1;
          nextState   = EXPAND;
        end
      end
      EXPAND: begin
        expandStep = 1'b1;
        if (roundCnt == LAST_ROUND) nextState = READY;
      end
      READY: begin
        if (start) begin
          startAccept = 1'b1;
          nextState   = EXPAND;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign lastStep = expandStep && (roundCnt == LAST_ROUND);

  // roundCnt is 0 only before the first start; clamp so the mux never indexes past slot 0.
  assign prevIdx = (roundCnt == 4'd0) ? 4'd0 : roundCnt - 4'd1;
  assign prevKey = store[prevIdx];

  KeyExpansionRound uRound (
    .roundCount (roundCnt),
    .keyIn      (prevKey),
    .keyOut     (nextKey)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roundCnt  <= 4'd0;
      validMask <= '0;
      doneReg   <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
    end else begin
      doneReg <= lastStep;
      if (startAccept) begin
        store[0]  <= keyIn;
        validMask <= {{NUM_ROUNDS{1'b0}}, 1'b1};
        roundCnt  <= 4'd1;
      end else if (expandStep) begin
        store[roundCnt]     <= nextKey;
        validMask[roundCnt] <= 1'b1;
        if (!lastStep) roundCnt <= roundCnt + 4'd1;
      end
    end
  end

  // A key accepted this edge invalidates whatever the store held, so never flag it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdKey   <= '0;
      rdValid <= 1'b0;
    end else if (rdRound > LAST_ROUND) begin
      rdKey   <= '0;
      rdValid <= 1'b0;
    end else begin
      rdKey   <= store[rdRound];
      rdValid <= validMask[rdRound] && !startAccept;
    end
  end

  for (genvar r = 0; r <= NUM_ROUNDS; r++) begin : gFlat
    assign keysOut[r*KEY_W +: KEY_W] = store[r];
  end

  assign busy  = (state == EXPAND);
  assign ready = (state == READY);
  assign done  = doneReg;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 key-expansion vectors.
module tb_key_schedule_ctrl;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start;
  logic [127:0]  keyIn;
  logic          busy, ready, done;
  logic [3:0]    rdRound;
  logic [127:0]  rdKey;
  logic          rdValid;
  logic [1407:0] keysOut;

  int errors = 0;
  int checks = 0;

  logic [127:0] keyA, keyB;
  logic [127:0] expA [0:10];
  logic [127:0] expB1, expB10;

  int busyN, doneN, doneAt, n;

  key_schedule_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .keyIn   (keyIn),
    .busy    (busy),
    .ready   (ready),
    .done    (done),
    .rdRound (rdRound),
    .rdKey   (rdKey),
    .rdValid (rdValid),
    .keysOut (keysOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] slot(input int r);
    return keysOut[128*r +: 128];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    keyA    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keyB    = 128'h000102030405060708090a0b0c0d0e0f;
    expA[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expA[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    expA[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    expA[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    expA[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    expA[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    expA[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    expA[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    expA[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    expA[9]  = 128'hac7766f319fadc2128d12941575c006e;
    expA[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    expB1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    expB10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    start = 1'b0;
    keyIn = '0;
    rdRound = 4'd0;

    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_rdKey", rdKey, 0);
    chk("rst_rdValid", rdValid, 0);
    chk("rst_keysOut", |keysOut, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // first expansion from IDLE, with an early read of round 5
    keyIn = keyA;
    start = 1'b1;
    tick();
    start = 1'b0;
    busyN = 0; doneN = 0; doneAt = -1;
    for (int k = 0; k < 20; k++) begin
      if (busy) busyN++;
      if (done) begin
        doneN++;
        if (doneAt < 0) doneAt = k;
      end
      if (k == 5) chk("early_rd5_valid", rdValid, 0);
      if (k == 6) begin
        chk("rd5_valid", rdValid, 1);
        chk("rd5_key", rdKey, expA[5]);
      end
      if (k == 4 || k == 5) rdRound = 4'd5;
      tick();
    end
    chk("a_busy_cycles", busyN, 10);
    chk("a_done_at", doneAt, 10);
    chk("a_done_count", doneN, 1);
    chk("a_ready", ready, 1);
    chk("a_slot0", slot(0), expA[0]);
    chk("a_slot1", slot(1), expA[1]);
    chk("a_slot10", slot(10), expA[10]);

    // restart from READY; read each round the cycle after it is written
    rdRound = 4'd0;
    tick();
    keyIn = keyA;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovl_start_rdValid", rdValid, 0);
    chk("ovl_start_ready", ready, 0);
    chk("ovl_start_busy", busy, 1);
    for (int k = 0; k <= 10; k++) begin
      rdRound = 4'(k);
      tick();
      chk($sformatf("ovl_valid_%0d", k), rdValid, 1);
      chk($sformatf("ovl_key_%0d", k), rdKey, expA[k]);
      chk($sformatf("ovl_done_%0d", k), done, (k == 9) ? 1 : 0);
    end

    // out-of-range read indices
    rdRound = 4'd10;
    tick();
    chk("rd10_valid", rdValid, 1);
    chk("rd10_key", rdKey, expA[10]);
    rdRound = 4'd11;
    tick();
    chk("rd11_key", rdKey, 0);
    chk("rd11_valid", rdValid, 0);
    rdRound = 4'd15;
    tick();
    chk("rd15_key", rdKey, 0);
    chk("rd15_valid", rdValid, 0);
    rdRound = 4'd0;

    // start pulsed during EXPAND must be ignored
    keyIn = keyA;
    start = 1'b1;
    tick();
    start = 1'b0;
    busyN = 0; doneN = 0; doneAt = -1;
    for (int k = 0; k < 20; k++) begin
      if (busy) busyN++;
      if (done) begin
        doneN++;
        if (doneAt < 0) doneAt = k;
      end
      if (k == 3) begin
        keyIn = keyB;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("ign_busy_cycles", busyN, 10);
    chk("ign_done_at", doneAt, 10);
    chk("ign_done_count", doneN, 1);
    chk("ign_slot0", slot(0), expA[0]);
    chk("ign_slot10", slot(10), expA[10]);

    // restart from READY with a new key
    rdRound = 4'd10;
    keyIn = keyB;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_start_rdValid", rdValid, 0);
    chk("b_start_ready", ready, 0);
    chk("b_slot0", slot(0), keyB);
    tick();
    chk("b_mask10_cleared", rdValid, 0);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("b_done_at", n, 10);
    chk("b_slot1", slot(1), expB1);
    chk("b_slot10", slot(10), expB10);

    // async reset in the middle of EXPAND
    rdRound = 4'd0;
    keyIn = keyA;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdKey", rdKey, 0);
    chk("mid_rst_rdValid", rdValid, 0);
    chk("mid_rst_keysOut", |keysOut, 0);
    tick();
    tick();
    reset = 1'b0;
    busyN = 0; doneN = 0;
    for (int k = 0; k < 15; k++) begin
      if (busy) busyN++;
      if (done) doneN++;
      tick();
    end
    chk("post_rst_done_count", doneN, 0);
    chk("post_rst_busy_count", busyN, 0);

    // full schedule after the aborted run
    keyIn = keyA;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("c_done_at", n, 10);
    for (int r = 0; r <= 10; r++) chk($sformatf("c_slot%0d", r), slot(r), expA[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
